// File: rtl/pos_embed_sequencer_if.sv
// Handshake bundle between the position-embedding sequencer, its table and downstream consumer.
// The master modport is the controlling/consuming side; the slave modport is the sequencer.
interface pos_embed_sequencer_if #(
    parameter int unsigned N_POS  = 8,
    parameter int unsigned N_EMBD = 4,
    parameter int unsigned DW     = 8
);
    localparam int unsigned PW = $clog2(N_POS);
    localparam int unsigned EW = N_EMBD * DW;

    logic          start;
    logic [PW:0]   seq_len;
    logic          abort;
    logic          busy;
    logic          done;
    logic [PW-1:0] rom_pos;
    logic [EW-1:0] rom_emb;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pos;
    logic [EW-1:0] out_emb;
    logic          out_last;

    modport master (
        output start, seq_len, abort, rom_emb, out_ready,
        input  busy, done, rom_pos, out_valid, out_pos, out_emb, out_last
    );

    modport slave (
        input  start, seq_len, abort, rom_emb, out_ready,
        output busy, done, rom_pos, out_valid, out_pos, out_emb, out_last
    );
endinterface

// File: rtl/pos_embed_sequencer.sv
// Streams pos_embedding rows 0..len-1 out on valid/ready, tagged with their position.
// Table reads are issued one cycle ahead and land in a 2-entry output FIFO.
module pos_embed_sequencer #(
    parameter int unsigned N_POS  = 8,
    parameter int unsigned N_EMBD = 4,
    parameter int unsigned DW     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pos_embed_sequencer_if.slave  bus
);
    localparam int unsigned PW = $clog2(N_POS);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = N_EMBD * DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic [CW-1:0] r_len;
    logic [CW-1:0] r_issue_cnt;
    logic          r_inflight;
    logic [PW-1:0] r_inf_pos;
    logic          r_inf_last;
    logic [1:0]    r_occ;
    logic [PW-1:0] r_pos0, r_pos1;
    logic [EW-1:0] r_emb0, r_emb1;
    logic          r_last0, r_last1;

    logic          w_pop;
    logic [1:0]    w_sum;
    logic          w_slot;
    logic          w_issue;
    logic          w_issue_last;
    logic [CW-1:0] w_len;

    // Issue/pop decisions; a pop in the same cycle frees a slot for a new read.
    always_comb begin
        w_pop        = (r_occ != 2'd0) && bus.out_ready;
        w_sum        = r_occ + {1'b0, r_inflight};
        w_slot       = (w_sum < 2'd2) || ((w_sum == 2'd2) && w_pop);
        w_issue      = (r_state == S_RUN) && (r_issue_cnt < r_len) && w_slot && !bus.abort;
        w_issue_last = (r_issue_cnt == (r_len - CW'(1)));
        w_len        = (bus.seq_len > CW'(N_POS)) ? CW'(N_POS) : bus.seq_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_inflight  <= 1'b0;
            r_inf_pos   <= '0;
            r_inf_last  <= 1'b0;
            r_occ       <= 2'd0;
            r_pos0      <= '0;
            r_pos1      <= '0;
            r_emb0      <= '0;
            r_emb1      <= '0;
            r_last0     <= 1'b0;
            r_last1     <= 1'b0;
        end else if (bus.abort) begin
            // Flush everything, including a table read still in flight.
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_len       <= w_len;
                        r_issue_cnt <= '0;
                        if (bus.seq_len == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_pop && r_last0) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            r_inflight <= w_issue;
            if (w_issue) begin
                r_inf_pos   <= r_issue_cnt[PW-1:0];
                r_inf_last  <= w_issue_last;
                r_issue_cnt <= r_issue_cnt + CW'(1);
            end

            // Two-entry FIFO; entry 0 is the head presented on the output.
            case (r_occ)
                2'd0: begin
                    if (r_inflight) begin
                        r_pos0  <= r_inf_pos;
                        r_emb0  <= bus.rom_emb;
                        r_last0 <= r_inf_last;
                        r_occ   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_pop) begin
                        r_pos0  <= r_inf_pos;
                        r_emb0  <= bus.rom_emb;
                        r_last0 <= r_inf_last;
                    end else if (r_inflight) begin
                        r_pos1  <= r_inf_pos;
                        r_emb1  <= bus.rom_emb;
                        r_last1 <= r_inf_last;
                        r_occ   <= 2'd2;
                    end else if (w_pop) begin
                        r_occ   <= 2'd0;
                    end
                end
                2'd2: begin
                    if (w_pop) begin
                        r_pos0  <= r_pos1;
                        r_emb0  <= r_emb1;
                        r_last0 <= r_last1;
                        if (r_inflight) begin
                            r_pos1  <= r_inf_pos;
                            r_emb1  <= bus.rom_emb;
                            r_last1 <= r_inf_last;
                        end else begin
                            r_occ   <= 2'd1;
                        end
                    end
                end
                default: r_occ <= 2'd0;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.rom_pos   = r_issue_cnt[PW-1:0];
    assign bus.out_valid = (r_occ != 2'd0);
    assign bus.out_pos   = r_pos0;
    assign bus.out_emb   = r_emb0;
    assign bus.out_last  = r_last0;

endmodule
